can_bit_sampler: RTL and testbench

Bit-timing and sampling front end of the CAN receive path. It synchronises the raw CAN Rx pin, detects bus idle, hard-synchronises on the start-of-frame falling edge, and samples every bit at the programmed sample point. It emits `sof`, `din` and `dvalid` to the frame-length/field-decode stage. That stage returns `sample_en`, which tells this block when the frame is over.

---
 rtl/can_pkg.sv | 24 ++
 rtl/can_rx_sync.sv | 30 +++
 rtl/can_bit_sampler.sv | 189 ++++++++++++++++++
 tb/tb_can_bit_sampler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: sampler states, bus levels and bit-timing helpers
// used by both the receive sampler and the transmitter.
package can_pkg;

    typedef enum logic [2:0] {
        ST_INTEGRATE,
        ST_IDLE,
        ST_SOF_CHK,
        ST_RECEIVE,
        ST_INTERMISSION
    } sampler_state_t;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    function automatic int can_bit_clks(input int clk_mhz, input int rate_kbits);
        return (clk_mhz * 1000) / rate_kbits;
    endfunction

    function automatic int can_sample_clks(input int bit_clks, input int pct);
        return (bit_clks * pct) / 100;
    endfunction

endpackage

// File: rtl/can_rx_sync.sv
// Two-flop synchronizer for the raw CAN Rx pin plus falling-edge detect on
// the synchronised level. Resets to recessive so reset never looks like SOF.
module can_rx_sync
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_m;
    logic rx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= CAN_RECESSIVE;
            rx_s <= CAN_RECESSIVE;
            rx_d <= CAN_RECESSIVE;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/can_bit_sampler.sv
// CAN receive bit sampler: bus integration, SOF hard sync and per-bit sampling.
// Optional soft resynchronisation within a frame when CAN_SOFT_RESYNC_EN is defined.
//   state        | meaning
//   INTEGRATE    | after reset, waiting for idle_bits recessive samples
//   IDLE         | bus idle, falling edge hard-syncs
//   SOF_CHK      | confirm SOF is still dominant at the sample point
//   RECEIVE      | sampling frame bits while sample_en is high
//   INTERMISSION | waiting for intermission_bits recessive samples
module can_bit_sampler
    import can_pkg::*;
#(
    parameter int clk_speed_MHz      = 100,
    parameter int can_bit_rate_Kbits = 1000,
    parameter int sample_point_pct   = 75,
    parameter int sjw_clks           = 10,
    parameter int idle_bits          = 11,
    parameter int intermission_bits  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic sample_en,
    output logic sof,
    output logic din,
    output logic dvalid,
    output logic bus_idle
);

    localparam int BP   = can_bit_clks(clk_speed_MHz, can_bit_rate_Kbits);
    localparam int SP   = can_sample_clks(BP, sample_point_pct);
    localparam int TQW  = $clog2(BP);
    localparam int CNTW = $clog2(idle_bits + intermission_bits + 1);

    localparam logic [TQW-1:0]  TQ_LAST  = TQW'(BP - 1);
    localparam logic [TQW-1:0]  TQ_SMP   = TQW'(SP - 1);
    localparam logic [TQW-1:0]  TQ_ONE   = TQW'(1);
    localparam logic [CNTW-1:0] IDLE_CNT = CNTW'(idle_bits);
    localparam logic [CNTW-1:0] IMS_CNT  = CNTW'(intermission_bits);

    if ((BP * can_bit_rate_Kbits != clk_speed_MHz * 1000) ||
        (sjw_clks >= SP) || (sjw_clks >= BP - SP)) begin : g_bad_timing
        $error("can_bit_sampler: inconsistent bit timing parameters");
    end

    logic           rx_s;
    logic           fall;
    sampler_state_t state, state_nxt;
    logic [TQW-1:0]  tq, tq_nxt, tq_run;
    logic [CNTW-1:0] rcnt, rcnt_nxt, rcnt_tgt;
    logic           sof_nxt, dvalid_nxt, din_nxt;
    logic           smp;
    logic           rs_hit;
    logic [TQW-1:0]  rs_tq;

    can_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    assign smp      = (tq == TQ_SMP);
    assign tq_run   = (tq == TQ_LAST) ? '0 : tq + TQ_ONE;
    assign rcnt_tgt = (state == ST_INTEGRATE) ? IDLE_CNT : IMS_CNT;

`ifdef CAN_SOFT_RESYNC_EN
    localparam logic [TQW-1:0] SJW_TQ    = TQW'(sjw_clks);
    localparam logic [TQW-1:0] SP_TQ     = TQW'(SP);
    localparam logic [TQW-1:0] EARLY_LIM = TQW'(BP - sjw_clks);

    logic prev_bit;
    logic rs_done;

    // Late edges stretch the bit, early edges shorten it, both bounded by SJW.
    always_comb begin
        rs_hit = 1'b0;
        rs_tq  = tq_run;
        if (state == ST_RECEIVE && fall && prev_bit == CAN_RECESSIVE &&
            !rs_done && tq != '0) begin
            rs_hit = 1'b1;
            if (tq < SP_TQ)
                rs_tq = (tq > SJW_TQ) ? tq - SJW_TQ : '0;
            else if (tq >= EARLY_LIM)
                rs_tq = '0;
            else
                rs_tq = tq + SJW_TQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit <= CAN_RECESSIVE;
            rs_done  <= 1'b0;
        end else begin
            if (smp && (state == ST_SOF_CHK || state == ST_RECEIVE))
                prev_bit <= rx_s;
            if (state != ST_RECEIVE)
                rs_done <= 1'b0;
            else if (rs_hit)
                rs_done <= 1'b1;
            else if (smp)
                rs_done <= 1'b0;
        end
    end
`else
    assign rs_hit = 1'b0;
    assign rs_tq  = '0;
`endif

    always_comb begin
        state_nxt  = state;
        tq_nxt     = tq_run;
        rcnt_nxt   = rcnt;
        sof_nxt    = 1'b0;
        dvalid_nxt = 1'b0;
        din_nxt    = din;
        case (state)
            ST_INTEGRATE, ST_INTERMISSION: begin
                if (smp) begin
                    if (rx_s == CAN_RECESSIVE) begin
                        if (rcnt + CNTW'(1) == rcnt_tgt) begin
                            state_nxt = ST_IDLE;
                            rcnt_nxt  = '0;
                        end else begin
                            rcnt_nxt = rcnt + CNTW'(1);
                        end
                    end else begin
                        rcnt_nxt = '0;
                    end
                end
            end
            ST_IDLE: begin
                // The edge cycle itself counts as tq 0.
                if (fall) begin
                    tq_nxt    = TQ_ONE;
                    state_nxt = ST_SOF_CHK;
                end
            end
            ST_SOF_CHK: begin
                if (smp) begin
                    if (rx_s == CAN_DOMINANT) begin
                        sof_nxt    = 1'b1;
                        dvalid_nxt = 1'b1;
                        din_nxt    = CAN_DOMINANT;
                        state_nxt  = ST_RECEIVE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RECEIVE: begin
                if (rs_hit)
                    tq_nxt = rs_tq;
                if (smp) begin
                    if (sample_en) begin
                        dvalid_nxt = 1'b1;
                        din_nxt    = rx_s;
                    end else begin
                        state_nxt = ST_INTERMISSION;
                        rcnt_nxt  = '0;
                    end
                end
            end
            default: state_nxt = ST_INTEGRATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INTEGRATE;
            tq       <= '0;
            rcnt     <= '0;
            sof      <= 1'b0;
            dvalid   <= 1'b0;
            din      <= CAN_RECESSIVE;
            bus_idle <= 1'b0;
        end else begin
            state    <= state_nxt;
            tq       <= tq_nxt;
            rcnt     <= rcnt_nxt;
            sof      <= sof_nxt;
            dvalid   <= dvalid_nxt;
            din      <= din_nxt;
            bus_idle <= (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_can_bit_sampler.sv
// Self-checking bench for can_bit_sampler: random frames and glitches compared
// against a sample-time reference model built from the recorded pin history.
module tb_can_bit_sampler;

    localparam int BP   = 100;
    localparam int SPC  = 75;
    localparam int MAXC = 40000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic sample_en = 1'b0;
    logic sof, din, dvalid, bus_idle;

    can_bit_sampler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .sample_en (sample_en),
        .sof       (sof),
        .din       (din),
        .dvalid    (dvalid),
        .bus_idle  (bus_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rx_hist [MAXC];
    bit se_hist [MAXC];
    int ev_cyc[$];
    bit ev_din[$];
    bit ev_sof[$];
    bit ev_dv[$];
    int idle_rise = -1;
    bit idle_q = 1'b0;

    int exp_cyc[$];
    bit exp_din[$];
    bit exp_sof[$];
    int exp_idle;

    int vectors = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            rx_hist[cyc] = rx;
            se_hist[cyc] = sample_en;
        end
        if (dvalid === 1'b1 || sof === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_din.push_back(din);
            ev_sof.push_back(sof);
            ev_dv.push_back(dvalid);
        end
        if (bus_idle === 1'b1 && !idle_q) idle_rise = cyc;
        idle_q = (bus_idle === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        ev_cyc.delete();
        ev_din.delete();
        ev_sof.delete();
        ev_dv.delete();
        idle_rise = -1;
    endtask

    function automatic bit rxs(input int t);
        return (t >= 2 && t < MAXC + 2) ? rx_hist[t-2] : 1'b1;
    endfunction

    // Reference: sample points sit every BP cycles from the hard-sync edge,
    // outputs one cycle later; 3 recessive samples after the frame end.
    task automatic model_frame(input int e);
        int t;
        int cnt;
        exp_cyc.delete();
        exp_din.delete();
        exp_sof.delete();
        exp_idle = -1;
        t = e + SPC - 1;
        if (rxs(t) != 1'b0) begin
            exp_idle = t + 1;
            return;
        end
        exp_cyc.push_back(t + 1);
        exp_din.push_back(1'b0);
        exp_sof.push_back(1'b1);
        for (int k = 0; k < 64; k++) begin
            t += BP;
            if (t >= MAXC || !se_hist[t]) break;
            exp_cyc.push_back(t + 1);
            exp_din.push_back(rxs(t));
            exp_sof.push_back(1'b0);
        end
        cnt = 0;
        for (int k = 0; k < 32 && cnt < 3; k++) begin
            t += BP;
            cnt = rxs(t) ? cnt + 1 : 0;
        end
        exp_idle = t + 1;
    endtask

    task automatic compare_frame(input string tag);
        int n;
        n = (ev_cyc.size() < exp_cyc.size()) ? ev_cyc.size() : exp_cyc.size();
        check({tag, ".count"}, ev_cyc.size(), exp_cyc.size());
        for (int i = 0; i < n; i++) begin
            check({tag, ".cycle"}, ev_cyc[i], exp_cyc[i]);
            check({tag, ".din"}, ev_din[i], exp_din[i]);
            check({tag, ".sof"}, ev_sof[i], exp_sof[i]);
            check({tag, ".dvalid"}, ev_dv[i], 1);
        end
        check({tag, ".idle_rise"}, idle_rise, exp_idle);
    endtask

    task automatic send_frame(input bit [63:0] bits, input int n, input int bp,
                              input int tail, output int t0);
        clear_events();
        t0 = cyc;
        for (int i = 0; i < n * bp + tail; i++) begin
            rx = (i < n * bp) ? bits[i / bp] : 1'b1;
            sample_en = (i < n * bp + 10);
            tick();
        end
    endtask

    initial begin
        int t0;
        int lat;
        int n;
        int len;
        bit [63:0] bits;

        rst_n = 1'b0;
        rx = 1'b1;
        sample_en = 1'b0;
        repeat (3) tick();
        check("reset.sof", sof, 0);
        check("reset.dvalid", dvalid, 0);
        check("reset.din", din, 1);
        check("reset.bus_idle", bus_idle, 0);

        rst_n = 1'b1;
        clear_events();
        t0 = cyc;
        for (int i = 0; i < 1300 && bus_idle !== 1'b1; i++) tick();
        lat = cyc - t0;
        check("integrate.bus_idle", bus_idle, 1);
        check("integrate.latency", (lat >= 1070 && lat <= 1080) ? 1075 : lat, 1075);
        check("integrate.no_output", ev_cyc.size(), 0);

        for (int g = 0; g < 3; g++) begin
            repeat (20) tick();
            clear_events();
            len = $urandom_range(1, 60);
            t0 = cyc;
            for (int i = 0; i < 90; i++) begin
                rx = (i < len) ? 1'b0 : 1'b1;
                if (i == 3)  check("glitch.left_idle", bus_idle, 0);
                if (i == 76) check("glitch.sample_cycle", bus_idle, 0);
                if (i == 77) check("glitch.back_idle", bus_idle, 1);
                tick();
            end
            check("glitch.no_output", ev_cyc.size(), 0);
        end

        for (int f = 0; f < 4; f++) begin
            sample_en = 1'($urandom_range(0, 1));
            repeat (30) tick();
            check("frame.pre_idle", bus_idle, 1);
            n = $urandom_range(5, 25);
            bits = {$urandom, $urandom};
            bits[0] = 1'b0;
            send_frame(bits, n, BP, 500, t0);
            model_frame(t0 + 2);
            compare_frame("frame");
        end

        repeat (30) tick();
        bits = {$urandom, $urandom};
        bits[0] = 1'b0;
        for (int k = 1; k < 20; k++) begin
            if (k % 3 == 1) bits[k] = 1'b1;
            if (k % 3 == 2) bits[k] = 1'b0;
        end
        send_frame(bits, 20, 104, 600, t0);
`ifdef CAN_SOFT_RESYNC_EN
        check("slow.count", ev_cyc.size(), 20);
        for (int k = 0; k < 20 && k < ev_cyc.size(); k++) begin
            check("slow.din", ev_din[k], bits[k]);
            check("slow.sof", ev_sof[k], (k == 0) ? 1 : 0);
        end
        check("slow.idle", bus_idle, 1);
`else
        model_frame(t0 + 2);
        compare_frame("slow");
`endif

        repeat (30) tick();
        bits = {$urandom, $urandom};
        bits[0] = 1'b0;
        bits[4] = 1'b0;
        clear_events();
        t0 = cyc;
        for (int i = 0; i < 500; i++) begin
            rx = bits[i / BP];
            sample_en = 1'b1;
            if (i == 477) begin
                check("midframe.dvalid", dvalid, 1);
                check("midframe.din", din, 0);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("midreset.sof", sof, 0);
        check("midreset.dvalid", dvalid, 0);
        check("midreset.din", din, 1);
        check("midreset.bus_idle", bus_idle, 0);
        rx = 1'b1;
        sample_en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clear_events();
        t0 = cyc;
        repeat (1000) tick();
        check("midreset.still_integrating", bus_idle, 0);
        for (int i = 0; i < 300 && bus_idle !== 1'b1; i++) tick();
        lat = cyc - t0;
        check("midreset.latency", (lat >= 1070 && lat <= 1080) ? 1075 : lat, 1075);
        check("midreset.no_output", ev_cyc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
